operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 115 +++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand fetch with a register scoreboard, RAW/WAW stalls and a one-deep output register.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data into the operands.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef REGADDR_SIZE
`define REGADDR_SIZE 5
`endif

module operand_fetch #(
   parameter int W = `WORD_SIZE,
   parameter int A = `REGADDR_SIZE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [A-1:0] in_src_a,
   input  logic [A-1:0] in_src_b,
   input  logic [A-1:0] in_dst,
   input  logic         in_dst_en,
   output logic [A-1:0] rf_addr_a,
   output logic [A-1:0] rf_addr_b,
   input  logic [W-1:0] rf_dout_a,
   input  logic [W-1:0] rf_dout_b,
   input  logic         wb_valid,
   input  logic [A-1:0] wb_addr,
   input  logic [W-1:0] wb_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_op_a,
   output logic [W-1:0] out_op_b,
   output logic [A-1:0] out_dst,
   output logic         out_dst_en
);
   localparam int NREG = 1 << A;

   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] w_pending_next;
   logic            r_out_valid;
   logic [W-1:0]    r_op_a;
   logic [W-1:0]    r_op_b;
   logic [A-1:0]    r_dst;
   logic            r_dst_en;

   logic         w_byp_a;
   logic         w_byp_b;
   logic         w_haz_a;
   logic         w_haz_b;
   logic         w_haz_d;
   logic         w_fire;
   logic [W-1:0] w_op_a;
   logic [W-1:0] w_op_b;

   assign rf_addr_a = in_src_a;
   assign rf_addr_b = in_src_b;

`ifdef OPERAND_FETCH_BYPASS_EN
   assign w_byp_a = wb_valid && (wb_addr == in_src_a);
   assign w_byp_b = wb_valid && (wb_addr == in_src_b);
   assign w_op_a  = w_byp_a ? wb_data : rf_dout_a;
   assign w_op_b  = w_byp_b ? wb_data : rf_dout_b;
`else
   logic w_unused_wb_data;
   assign w_byp_a = 1'b0;
   assign w_byp_b = 1'b0;
   assign w_op_a  = rf_dout_a;
   assign w_op_b  = rf_dout_b;
   assign w_unused_wb_data = ^wb_data;
`endif

   assign w_haz_a = r_pending[in_src_a] && !w_byp_a;
   assign w_haz_b = r_pending[in_src_b] && !w_byp_b;
   // A writeback retiring the old result of in_dst lifts the WAW stall in both builds.
   assign w_haz_d = in_dst_en && r_pending[in_dst] && !(wb_valid && (wb_addr == in_dst));

   assign in_ready = !(w_haz_a || w_haz_b || w_haz_d) && (!r_out_valid || out_ready);
   assign w_fire   = in_valid && in_ready;

   // Per-register scoreboard: a new issue to the same register wins over its writeback.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      assign w_pending_next[gi] = (w_fire && in_dst_en && (in_dst == A'(gi))) ? 1'b1 :
                                  (wb_valid && (wb_addr == A'(gi)))            ? 1'b0 :
                                  r_pending[gi];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending   <= '0;
         r_out_valid <= 1'b0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_dst       <= '0;
         r_dst_en    <= 1'b0;
      end else begin
         r_pending <= w_pending_next;
         if (w_fire) begin
            r_out_valid <= 1'b1;
            r_op_a      <= w_op_a;
            r_op_b      <= w_op_b;
            r_dst       <= in_dst;
            r_dst_en    <= in_dst_en;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_op_a   = r_op_a;
   assign out_op_b   = r_op_b;
   assign out_dst    = r_dst;
   assign out_dst_en = r_dst_en;

endmodule
